// File: rtl/digit_reg_bank.sv
// digit_reg_bank: a small bank of DEPTH entries, each holding DIGITS digits of
// DIGIT_W bits, with a valid bit per entry.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   write_en  load data_i into entry waddr
//   shift_en  shift entry waddr up one digit, digit_i enters digit 0
//   clear_en  zero every entry and valid bit (highest priority)
//   waddr     write/shift entry address
//   data_i    full entry, digit k at [k*DIGIT_W +: DIGIT_W]
//   digit_i   digit shifted in by shift_en
//   read_en   read request
//   raddr     read entry address
//   data_o    registered read data (held between reads)
//   rvalid_o  one-cycle pulse: data_o was loaded this cycle
//   rempty_o  entry read had not been written since reset/clear
//   err_o     one-cycle pulse: an out-of-range address was used
//   count_o   number of valid entries
module digit_reg_bank #(
    parameter int DIGITS  = 5,
    parameter int DIGIT_W = 3,
    parameter int DEPTH   = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write_en,
    input  logic                        shift_en,
    input  logic                        clear_en,
    input  logic [AW-1:0]               waddr,
    input  logic [DIGITS*DIGIT_W-1:0]   data_i,
    input  logic [DIGIT_W-1:0]          digit_i,
    input  logic                        read_en,
    input  logic [AW-1:0]               raddr,
    output logic [DIGITS*DIGIT_W-1:0]   data_o,
    output logic                        rvalid_o,
    output logic                        rempty_o,
    output logic                        err_o,
    output logic [AW:0]                 count_o
);

    localparam int EW = DIGITS * DIGIT_W;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [EW-1:0]    data_q, data_d;
    logic             rvalid_q, rvalid_d;
    logic             rempty_q, rempty_d;
    logic             err_q, err_d;
    logic [AW:0]      count_q, count_d;

    logic             waddr_ok_s, raddr_ok_s;
    logic             wr_req_s, wr_hit_s;
    logic [AW-1:0]    widx_s, ridx_s;
    logic [EW-1:0]    wr_val_s;

    // Address range decode and the value a write/shift would store this cycle.
    always_comb begin
        waddr_ok_s = ({1'b0, waddr} < DEPTH_C);
        raddr_ok_s = ({1'b0, raddr} < DEPTH_C);
        // Out-of-range addresses are folded to 0 so no array access leaves
        // the bank; their results are never used.
        widx_s     = waddr_ok_s ? waddr : '0;
        ridx_s     = raddr_ok_s ? raddr : '0;
        wr_req_s   = write_en | shift_en;
        wr_hit_s   = wr_req_s & waddr_ok_s & ~clear_en;
        if (write_en) begin
            wr_val_s = data_i;
        end else begin
            wr_val_s = {mem_q[widx_s][EW-DIGIT_W-1:0], digit_i};
        end
    end

    // Next storage state: clear beats write beats shift; also population count.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        count_d = '0;
        if (clear_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            valid_d = '0;
        end else if (wr_hit_s) begin
            mem_d[widx_s]   = wr_val_s;
            valid_d[widx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + (AW+1)'(valid_d[i]);
        end
    end

    // Read port with write-first bypass; clear and bad addresses read as empty.
    always_comb begin
        data_d   = data_q;
        rempty_d = rempty_q;
        rvalid_d = 1'b0;
        if (read_en) begin
            rvalid_d = 1'b1;
            if (!raddr_ok_s || clear_en) begin
                data_d   = '0;
                rempty_d = 1'b1;
            end else if (wr_hit_s && (widx_s == ridx_s)) begin
                data_d   = wr_val_s;
                rempty_d = 1'b0;
            end else begin
                data_d   = mem_q[ridx_s];
                rempty_d = ~valid_q[ridx_s];
            end
        end else begin
            rvalid_d = 1'b0;
        end
        err_d = (wr_req_s & ~waddr_ok_s) | (read_en & ~raddr_ok_s);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q  <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
            rempty_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            valid_q  <= valid_d;
            data_q   <= data_d;
            rvalid_q <= rvalid_d;
            rempty_q <= rempty_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign data_o   = data_q;
    assign rvalid_o = rvalid_q;
    assign rempty_o = rempty_q;
    assign err_o    = err_q;
    assign count_o  = count_q;

endmodule

// File: tb/tb_digit_reg_bank.sv
// Bench for digit_reg_bank: a DEPTH=4 and a DEPTH=3 instance share stimulus and
// are checked every cycle against an arithmetic model, plus literal checks.
module tb_digit_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en, shift_en, clear_en, read_en;
    logic [1:0]  waddr, raddr;
    logic [14:0] data_i;
    logic [2:0]  digit_i;

    logic [14:0] dout0, dout1;
    logic        rv0, rv1, re0, re1, er0, er1;
    logic [2:0]  cnt0, cnt1;

    int n_chk  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // model state, index 0 = DEPTH 4, index 1 = DEPTH 3
    int depth_m [2] = '{4, 3};
    int mem_m   [2][16];
    bit val_m   [2][16];
    int e_data  [2];
    bit e_rv    [2];
    bit e_re    [2];
    bit e_err   [2];
    int e_cnt   [2];

    digit_reg_bank #(.DIGITS(5), .DIGIT_W(3), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .write_en(write_en), .shift_en(shift_en),
        .clear_en(clear_en), .waddr(waddr), .data_i(data_i), .digit_i(digit_i),
        .read_en(read_en), .raddr(raddr), .data_o(dout0), .rvalid_o(rv0),
        .rempty_o(re0), .err_o(er0), .count_o(cnt0));

    digit_reg_bank #(.DIGITS(5), .DIGIT_W(3), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .write_en(write_en), .shift_en(shift_en),
        .clear_en(clear_en), .waddr(waddr), .data_i(data_i), .digit_i(digit_i),
        .read_en(read_en), .raddr(raddr), .data_o(dout1), .rvalid_o(rv1),
        .rempty_o(re1), .err_o(er1), .count_o(cnt1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pack(int d4, int d3, int d2, int d1, int d0);
        return (((d4 * 8 + d3) * 8 + d2) * 8 + d1) * 8 + d0;
    endfunction

    function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endfunction

    function automatic void model_reset(int k);
        for (int i = 0; i < 16; i++) begin
            mem_m[k][i] = 0;
            val_m[k][i] = 1'b0;
        end
        e_data[k] = 0; e_rv[k] = 1'b0; e_re[k] = 1'b0; e_err[k] = 1'b0; e_cnt[k] = 0;
    endfunction

    function automatic void model_step(int k);
        int d    = depth_m[k];
        int wa   = int'(waddr);
        int ra   = int'(raddr);
        bit wreq = write_en || shift_en;
        bit hit  = wreq && (wa < d) && !clear_en;
        int newv = 0;
        if (hit) newv = write_en ? int'(data_i) : (mem_m[k][wa] * 8 + int'(digit_i)) % 32768;
        e_err[k] = (wreq && wa >= d) || (read_en && ra >= d);
        e_rv[k]  = read_en;
        if (read_en) begin
            if (ra >= d || clear_en) begin
                e_data[k] = 0; e_re[k] = 1'b1;
            end else if (hit && wa == ra) begin
                e_data[k] = newv; e_re[k] = 1'b0;
            end else begin
                e_data[k] = mem_m[k][ra]; e_re[k] = !val_m[k][ra];
            end
        end
        if (clear_en) begin
            for (int i = 0; i < 16; i++) begin
                mem_m[k][i] = 0; val_m[k][i] = 1'b0;
            end
        end else if (hit) begin
            mem_m[k][wa] = newv; val_m[k][wa] = 1'b1;
        end
        e_cnt[k] = 0;
        for (int i = 0; i < d; i++) e_cnt[k] += int'(val_m[k][i]);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            else     model_step(k);
        end
    end

    function automatic void cmp(int k, logic [14:0] d, logic rv, logic re, logic er, logic [2:0] c);
        chk("data_o",   k, 32'(d),  32'(e_data[k]));
        chk("rvalid_o", k, 32'(rv), 32'(e_rv[k]));
        chk("rempty_o", k, 32'(re), 32'(e_re[k]));
        chk("err_o",    k, 32'(er), 32'(e_err[k]));
        chk("count_o",  k, 32'(c),  32'(e_cnt[k]));
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            cmp(0, dout0, rv0, re0, er0, cnt0);
            cmp(1, dout1, rv1, re1, er1, cnt1);
        end
    end

    task automatic drive(bit we, bit se, bit ce, int wa, int d, int di, bit re, int ra);
        write_en = we; shift_en = se; clear_en = ce;
        waddr = wa[1:0]; data_i = d[14:0]; digit_i = di[2:0];
        read_en = re; raddr = ra[1:0];
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    int x;

    initial begin
        rst = 1'b1;
        write_en = 1'b0; shift_en = 1'b0; clear_en = 1'b0; read_en = 1'b0;
        waddr = 2'd0; raddr = 2'd0; data_i = 15'd0; digit_i = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        chk("reset_data", 0, 32'(dout0), 32'd0);
        chk("reset_count", 0, 32'(cnt0), 32'd0);

        // full write then read back
        x = pack(4, 3, 2, 1, 7);
        drive(1'b1, 1'b0, 1'b0, 2, x, 0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 2);
        chk("wr_rd_data", 0, 32'(dout0), 32'(x));
        chk("wr_rd_rvalid", 0, 32'(rv0), 32'd1);
        chk("wr_rd_rempty", 0, 32'(re0), 32'd0);
        chk("wr_rd_count", 0, 32'(cnt0), 32'd1);
        chk("wr_rd_data", 1, 32'(dout1), 32'(x));

        // six shifts into entry 0, oldest digit falls off the top
        for (int i = 1; i <= 6; i++) drive(1'b0, 1'b1, 1'b0, 0, 0, i, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 0);
        chk("shift_data", 0, 32'(dout0), 32'(pack(2, 3, 4, 5, 6)));
        chk("shift_model", 0, 32'(e_data[0]), 32'(pack(2, 3, 4, 5, 6)));
        chk("shift_count", 0, 32'(cnt0), 32'd2);

        // write and read same address same cycle
        drive(1'b1, 1'b0, 1'b0, 1, 32'h7fff, 0, 1'b1, 1);
        chk("bypass_data", 0, 32'(dout0), 32'h7fff);
        chk("bypass_rempty", 0, 32'(re0), 32'd0);

        // unwritten entry 3; out of range for the DEPTH 3 instance
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 3);
        chk("unwritten_rempty", 0, 32'(re0), 32'd1);
        chk("oor_read_data", 1, 32'(dout1), 32'd0);
        chk("oor_read_rempty", 1, 32'(re1), 32'd1);
        chk("oor_read_err", 1, 32'(er1), 32'd1);
        chk("inrange_read_err", 0, 32'(er0), 32'd0);

        // shift with read bypass on entry 2
        drive(1'b0, 1'b1, 1'b0, 2, 0, 5, 1'b1, 2);
        chk("shift_bypass", 0, 32'(dout0), 32'(pack(3, 2, 1, 7, 5)));

        // fill entry 3: valid for DEPTH 4, rejected by DEPTH 3
        drive(1'b1, 1'b0, 1'b0, 3, pack(1, 1, 1, 1, 1), 0, 1'b0, 0);
        chk("full_count", 0, 32'(cnt0), 32'd4);
        chk("oor_write_err", 1, 32'(er1), 32'd1);
        chk("oor_write_count", 1, 32'(cnt1), 32'd3);
        idle();
        chk("err_pulse_end", 1, 32'(er1), 32'd0);

        // clear with simultaneous read
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 3);
        chk("clear_data", 0, 32'(dout0), 32'd0);
        chk("clear_rempty", 0, 32'(re0), 32'd1);
        chk("clear_count", 0, 32'(cnt0), 32'd0);
        chk("clear_count", 1, 32'(cnt1), 32'd0);

        // rewriting a valid entry leaves the count alone
        drive(1'b1, 1'b0, 1'b0, 0, 5, 0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 6, 0, 1'b0, 0);
        chk("rewrite_count", 0, 32'(cnt0), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 0);
        chk("rewrite_data", 0, 32'(dout0), 32'd6);

        // asynchronous reset between clock edges
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", 0, 32'(dout0), 32'd0);
        chk("async_rst_count", 0, 32'(cnt0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 0);
        chk("post_rst_rempty", 0, 32'(re0), 32'd1);
        chk("post_rst_rvalid", 0, 32'(rv0), 32'd1);
        idle();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_reg_bank.md
DIGIT_REG_BANK -- requirements
Module: digit_reg_bank

Interface
REQ-001 SHALL provide parameter DIGITS, default 5, number of digits per entry.
REQ-002 SHALL provide parameter DIGIT_W, default 3, bits per digit (3 = octal).
REQ-003 SHALL provide parameter DEPTH, default 4, number of entries (2..16, any integer); AW = clog2(DEPTH), derived, not overridable.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port write_en  input  1  full-entry write request.
REQ-007 SHALL have port shift_en  input  1  digit shift-in request.
REQ-008 SHALL have port clear_en  input  1  synchronous clear of all entries.
REQ-009 SHALL have port waddr  input  AW  write/shift entry address.
REQ-010 SHALL have port data_i  input  DIGITS*DIGIT_W  full entry; digit k at bits [k*DIGIT_W +: DIGIT_W], digit 0 least significant.
REQ-011 SHALL have port digit_i  input  DIGIT_W  digit for shift-in.
REQ-012 SHALL have port read_en  input  1  read request.
REQ-013 SHALL have port raddr  input  AW  read entry address.
REQ-014 SHALL have port data_o  output  DIGITS*DIGIT_W  registered read data, same packing as data_i.
REQ-015 SHALL have port rvalid_o  output  1  one-cycle pulse, data_o updated this cycle.
REQ-016 SHALL have port rempty_o  output  1  entry read was unwritten since reset/clear; qualified by rvalid_o.
REQ-017 SHALL have port err_o  output  1  one-cycle pulse, out-of-range address used.
REQ-018 SHALL have port count_o  output  AW+1  number of written (valid) entries.

Function
REQ-019 SHALL store DEPTH entries of DIGITS*DIGIT_W bits plus one valid bit per entry, all state updated only on rising clk (except reset).
REQ-020 SHALL on write_en: mem[waddr] <= data_i, valid[waddr] <= 1.
REQ-021 SHALL on shift_en (write_en low): mem[waddr] <= mem[waddr] shifted up one digit, digit_i into digit 0, top digit discarded; valid[waddr] <= 1.
REQ-022 SHALL prioritise clear_en > write_en > shift_en; clear_en zeroes all entries and valid bits, and count_o reads 0 the next cycle.
REQ-023 SHALL on read_en: data_o <= mem[raddr], rempty_o <= ~valid[raddr], rvalid_o <= 1 after one clk (latency 1).
REQ-024 SHALL hold data_o and rempty_o when read_en low; rvalid_o low that cycle.
REQ-025 SHALL, for read and write/shift to same address same cycle, return the newly written value (write-first bypass) with rempty_o = 0.
REQ-026 SHALL, for read with clear_en same cycle, return zero with rempty_o = 1.
REQ-027 SHALL ignore write/shift with waddr >= DEPTH (no state change) and pulse err_o next cycle.
REQ-028 SHALL, for read with raddr >= DEPTH, load data_o = 0, rempty_o = 1, rvalid_o = 1, and pulse err_o.
REQ-029 SHALL update count_o one cycle after any valid bit change; rewriting a valid entry leaves count_o unchanged; count_o never exceeds DEPTH.
REQ-030 SHALL allow read and write/shift/clear in every cycle with no stall.

Reset
REQ-031 SHALL on rst high, immediately and independent of clk: all entries 0, all valid bits 0, data_o = 0, rvalid_o = 0, rempty_o = 0, err_o = 0, count_o = 0.
REQ-032 SHALL ignore all requests while rst high; first clk edge after rst falls processes requests normally.

Verification
REQ-033 SHALL check: write_en waddr=2 data_i=digits{4,3,2,1,7}, next cycle read_en raddr=2 -> one cycle later data_o = same, rvalid_o = 1, rempty_o = 0, count_o = 1.
REQ-034 SHALL check: shift_en waddr=0 digits 1,2,3,4,5,6 on six cycles -> entry 0 digits (4..0) = {2,3,4,5,6}, digit 1 discarded.
REQ-035 SHALL check: write_en and read_en both at address 1, data_i all digits 7 -> data_o all 7 after one cycle (bypass), rempty_o = 0.
REQ-036 SHALL check: write all 4 entries, count_o = 4; clear_en with read_en raddr=3 -> data_o = 0, rempty_o = 1, count_o = 0.
REQ-037 SHALL check: DEPTH=3, write_en waddr=3 -> err_o pulse, count_o unchanged; read raddr=3 -> data_o = 0, rempty_o = 1, err_o pulse.
REQ-038 SHALL check: rst asserted mid-cycle between edges after writes -> data_o and count_o 0 without clk edge; reads afterwards return rempty_o = 1.
